// File: rtl/step_seq_pkg.sv
// Shared types and constants for the servo step sequencer.
package step_seq_pkg;

    // One 20 ms servo PWM frame at 50 MHz.
    localparam int unsigned DEFAULT_FRAME_CYCLES = 1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/step_sequencer_frame_tick_gen.sv
// Free-running frame counter; flags the last cycle of each frame while enabled.
module frame_tick_gen
    import step_seq_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEFAULT_FRAME_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic frame_end_c
);

    localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] FCNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] fcnt;

    assign frame_end_c = enable && (fcnt == FCNT_LAST);

    // Count 0..FRAME_CYCLES-1 while enabled; hold otherwise.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            fcnt <= '0;
        end else if (enable) begin
            fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Servo motion step timer: holds each sequence address for dwell+1 frames.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DWELL_W      = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop_en,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic [DWELL_W-1:0] dwell,
    output logic [ADDR_W-1:0]  addr,
    output logic               frame_tick,
    output logic               step_adv,
    output logic               wrap,
    output logic               busy,
    output logic               done
);

    localparam logic [DWELL_W-1:0] DCNT_MAX = '1;

    state_t             state, state_n;
    logic [DWELL_W-1:0] dcnt, dcnt_n;
    logic [ADDR_W-1:0]  addr_n;
    logic               frame_tick_n, step_adv_n, wrap_n, busy_n, done_n;
    logic               frame_end_c;
    logic               fcnt_clear_c;

    // Frame counter restarts whenever playback is not in progress or is aborted.
    assign fcnt_clear_c = stop || (state == IDLE) || (state == DONE);

    frame_tick_gen #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_tick_gen (
        .CLK         (CLK),
        .RST         (RST),
        .clear       (fcnt_clear_c),
        .enable      (state == RUN),
        .frame_end_c (frame_end_c)
    );

    // State, dwell counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            dcnt       <= '0;
            addr       <= '0;
            frame_tick <= 1'b0;
            step_adv   <= 1'b0;
            wrap       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            dcnt       <= dcnt_n;
            addr       <= addr_n;
            frame_tick <= frame_tick_n;
            step_adv   <= step_adv_n;
            wrap       <= wrap_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state, dwell/address update and pulse generation.
    always_comb begin
        state_n      = state;
        dcnt_n       = dcnt;
        addr_n       = addr;
        frame_tick_n = 1'b0;
        step_adv_n   = 1'b0;
        wrap_n       = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    dcnt_n  = '0;
                    addr_n  = '0;
                end
            end
            RUN: begin
                if (frame_end_c) begin
                    frame_tick_n = 1'b1;
                    // >= so a dwell lowered mid-step ends at the next frame end.
                    if (dcnt >= dwell) begin
                        step_adv_n = 1'b1;
                        dcnt_n     = '0;
                        if (addr != last_addr) begin
                            addr_n = addr + ADDR_W'(1);
                        end else if (loop_en) begin
                            addr_n = '0;
                            wrap_n = 1'b1;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        dcnt_n = (dcnt == DCNT_MAX) ? dcnt : dcnt + DWELL_W'(1);
                    end
                end
                // Frame end (if any) is processed first, then the block freezes.
                if (pause && (state_n == RUN)) begin
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (!pause) begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort wins over everything except reset.
        if (stop) begin
            state_n      = IDLE;
            dcnt_n       = '0;
            addr_n       = '0;
            frame_tick_n = 1'b0;
            step_adv_n   = 1'b0;
            wrap_n       = 1'b0;
        end

        busy_n = (state_n == RUN) || (state_n == PAUSE);
        done_n = (state_n == DONE);
    end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Parametrised step timer for the servo motion sequencer. It generates its own frame tick (one servo PWM frame, 20 ms at 50 MHz by default) and holds each sequence address for a per-step number of frames read from the dwell ROM. It then advances the address, with one-shot or looping playback plus start/stop/pause control. It sits between the motion ROMs (position and dwell, both addressed by `addr`) and the servo PWM channels.

## Interface
- `FRAME_CYCLES`, 1000000: clock cycles per frame; must be ≥ 2.
- `ADDR_W`, 8: sequence address width.
- `DWELL_W`, 8: dwell field width, in frames.
- `CLK` in 1: system clock; all logic on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled; begins playback from address 0 when in IDLE or DONE.
- `stop` in 1: abort to IDLE from any state.
- `pause` in 1: level; freezes all counters while high in RUN.
- `loop_en` in 1: 1 = wrap to address 0 after `last_addr`; 0 = stop in DONE.
- `last_addr` in ADDR_W: final valid address of the sequence.
- `dwell` in DWELL_W: dwell for the current `addr`, from the ROM; a step lasts `dwell`+1 frames.
- `addr` out ADDR_W: current sequence address.
- `frame_tick` out 1: one-cycle pulse per completed frame while running.
- `step_adv` out 1: one-cycle pulse when a step completes.
- `wrap` out 1: one-cycle pulse when `addr` wraps from `last_addr` to 0.
- `busy` out 1: high in RUN or PAUSE.
- `done` out 1: high in DONE.

## Operation
- States:
  - IDLE: `addr`=0 and counters cleared.
  - RUN.
  - PAUSE.
  - DONE: `addr` holds `last_addr`.
- Transitions:
  - IDLE/DONE → RUN when `start`. This clears the frame counter `fcnt`, the dwell counter `dcnt` and `addr`.
  - RUN → PAUSE when `pause`. PAUSE → RUN when `pause` is low. PAUSE holds `fcnt`, `dcnt` and `addr`.
  - Any state → IDLE when `stop`.
  - RUN → DONE at the final step completion with `loop_en`=0.
- Priority: `RST` > `stop` > `start` > `pause`. `start` in RUN or PAUSE is ignored. `start` and `stop` in the same cycle give IDLE.
- Frame count: in RUN, `fcnt` counts 0..FRAME_CYCLES-1 and wraps. A frame end is `fcnt`==FRAME_CYCLES-1.
- Step completion: at a frame end, if `dcnt` ≥ `dwell`, the step completes and `dcnt` returns to 0; otherwise `dcnt` increments.
  - The compare is ≥, so a `dwell` lowered mid-step ends the step at the next frame end instead of running 2^DWELL_W frames.
  - `dcnt` saturates at all-ones.
- On step completion:
  - if `addr` ≠ `last_addr`: `addr`+1.
  - if `addr` = `last_addr` and `loop_en`=1: `addr` ← 0 and `wrap` pulses.
  - if `addr` = `last_addr` and `loop_en`=0: state ← DONE and `addr` holds.
- `loop_en` and `last_addr` are sampled only at step completion.
- If `last_addr` < `addr` at step completion, `addr` increments and wraps naturally at 2^ADDR_W; not an error case.
- `dwell` is sampled only at frame ends. ROM read latency must be < FRAME_CYCLES cycles.

## Timing
- Every output is a register, and `RST` sets all of them to 0: `addr`=0, `frame_tick`=`step_adv`=`wrap`=0, `busy`=`done`=0, state IDLE.
- `start` sampled at edge N: `busy`=1 after edge N, and `fcnt`=0 in the first RUN cycle.
- First `frame_tick` comes after edge N+FRAME_CYCLES and lasts one cycle.
- A frame end detected at edge E gives, after edge E, simultaneously:
  - `frame_tick`=1;
  - `step_adv`=1 if the step completed;
  - the new `addr`, `wrap` or `done`.
- With dwell D, the first `step_adv` follows `start` by (D+1)·FRAME_CYCLES cycles.
- Pulses never last longer than one cycle. No `frame_tick`, `step_adv` or `wrap` is produced in PAUSE, IDLE or DONE.
- A `pause` asserted in the same cycle as a frame end: the frame end is processed, then the block enters PAUSE.
- Pause of length P delays all subsequent events by exactly P cycles.
- `stop` mid-step gives IDLE after one edge. The partial dwell is discarded, and a following `start` restarts from address 0 with a full step.

## Structure
- Package `step_seq_pkg`: state enum (IDLE, RUN, PAUSE, DONE) and constant `DEFAULT_FRAME_CYCLES` = 1000000 (20 ms at 50 MHz).
- Sub-module `frame_tick_gen`:
  - `fcnt` width $clog2(FRAME_CYCLES);
  - inputs `clear` and `enable`;
  - output: frame-end strobe.
- FSM, dwell counter and address logic live in the top module.

## Test plan
All scenarios use FRAME_CYCLES=4.
- `last_addr`=2, `dwell`=0 for all steps, `loop_en`=0, `start` at cycle 0 → `step_adv` at cycles 4, 8 and 12, with `addr` 1, 2, then DONE and `addr`=2 after cycle 12; `busy`=0 and `done`=1.
- `dwell`=2, `loop_en`=1, `last_addr`=1 → `step_adv` every 12 cycles, `addr` sequence 1, 0, 1, 0…, and `wrap` coincides with every second `step_adv`.
- `pause` held for 7 cycles mid-frame → all later `frame_tick`s shift by exactly 7 cycles, and `addr` and `dcnt` are unchanged across the pause.
- `dwell` lowered from 5 to 1 while `dcnt`=3 → step completes at the next frame end.
- `start` and `stop` in the same cycle while in IDLE → remains IDLE.
- `stop` during RUN, then `start` → `addr`=0 and full first step.
- `RST` asserted mid-RUN with `addr`=2 → after one edge all outputs are 0 and the state is IDLE.
- `RST` asserted together with `start` → IDLE.
